seg7_decoder: RTL

Reads a 7-segment pattern from a HEX-style bus and returns the hex digit it shows, so it is the reverse of the team's nibble-to-segment display encoders. The block synchronises the bus, waits for the pattern to stay stable, decodes it and presents one result per new pattern on a valid/ready handshake. It sits between a captured or looped-back display bus and downstream checking or logging logic. Invalid patterns are flagged, not dropped.

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_decoder_if.sv | 22 ++
 rtl/seg7_sync.sv | 27 ++
 rtl/seg7_decoder.sv | 128 ++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment table, blank code,
// decoder FSM encoding and the pattern-to-digit decode function.
package seg7_pkg;

  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    PEND   = 2'd2
  } seg7_state_t;

  typedef struct packed {
    logic       err;
    logic [3:0] digit;
  } seg7_res_t;

  // Unknown patterns report err with a zero digit
  function automatic seg7_res_t seg7_decode(input logic [6:0] p);
    seg7_res_t r;
    r.err   = 1'b1;
    r.digit = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (p == SEG7_TABLE[i]) begin
        r.err   = 1'b0;
        r.digit = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decoder_if.sv
// Result handshake bundle of the 7-segment decoder.
// master drives the result, slave consumes it.
interface seg7_decoder_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_digit;
  logic       out_err;

  modport master (
    output out_valid,
    output out_digit,
    output out_err,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_digit,
    input  out_err,
    output out_ready
  );
endinterface

// File: rtl/seg7_sync.sv
// Two-flop synchroniser for the 7-bit segment bus.
// Resets to the blank pattern so nothing spurious is decoded.
module seg7_sync
  import seg7_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_d,
  output logic [6:0] o_q
);

  logic [6:0] r_s1;
  logic [6:0] r_s2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= SEG7_BLANK;
      r_s2 <= SEG7_BLANK;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/seg7_decoder.sv
// Segment-bus to hex-digit decoder with settle filter and valid/ready.
// Define SEG7_DEC_ERRCNT_EN to add the saturating err_cnt output.
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic           CLOCK_50,
  input  logic           RST,
  input  logic [6:0]     SEG,
  seg7_decoder_if.master o_out
`ifdef SEG7_DEC_ERRCNT_EN
  ,
  output logic [7:0]     err_cnt
`endif
);

  localparam logic [7:0] LP_LAST = 8'(STABLE_CYCLES - 1);

  logic [6:0]  w_s;
  seg7_state_t r_state, w_state_n;
  logic [6:0]  r_last, w_last_n;
  logic [6:0]  r_cand, w_cand_n;
  logic [7:0]  r_cnt, w_cnt_n;
  logic        r_valid, w_valid_n;
  logic [3:0]  r_digit, w_digit_n;
  logic        r_err, w_err_n;
  seg7_res_t   w_dec;
  logic        w_err_inc;

  seg7_sync u_sync (
    .i_clk (CLOCK_50),
    .i_rst (RST),
    .i_d   (SEG),
    .o_q   (w_s)
  );

  assign w_dec = seg7_decode(r_cand);

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_state <= WAIT;
      r_last  <= SEG7_BLANK;
      r_cand  <= SEG7_BLANK;
      r_cnt   <= 8'd0;
      r_valid <= 1'b0;
      r_digit <= 4'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_last  <= w_last_n;
      r_cand  <= w_cand_n;
      r_cnt   <= w_cnt_n;
      r_valid <= w_valid_n;
      r_digit <= w_digit_n;
      r_err   <= w_err_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_last_n  = r_last;
    w_cand_n  = r_cand;
    w_cnt_n   = r_cnt;
    w_valid_n = r_valid;
    w_digit_n = r_digit;
    w_err_n   = r_err;
    w_err_inc = 1'b0;
    unique case (r_state)
      WAIT: begin
        if (w_s == SEG7_BLANK) begin
          w_last_n = SEG7_BLANK;
        end else if (w_s != r_last) begin
          w_cand_n  = w_s;
          w_cnt_n   = 8'd1;
          w_state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (w_s != r_cand) begin
          if (w_s == SEG7_BLANK) begin
            w_state_n = WAIT;
          end else begin
            w_cand_n = w_s;
            w_cnt_n  = 8'd1;
          end
        end else if (r_cnt == LP_LAST) begin
          w_valid_n = 1'b1;
          w_digit_n = w_dec.err ? 4'h0 : w_dec.digit;
          w_err_n   = w_dec.err;
          w_last_n  = r_cand;
          w_err_inc = w_dec.err;
          w_state_n = PEND;
        end else begin
          w_cnt_n = r_cnt + 8'd1;
        end
      end
      PEND: begin
        if (r_valid && o_out.out_ready) begin
          w_valid_n = 1'b0;
          w_state_n = WAIT;
        end
      end
      default: w_state_n = WAIT;
    endcase
  end

  assign o_out.out_valid = r_valid;
  assign o_out.out_digit = r_digit;
  assign o_out.out_err   = r_err;

`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST)
      r_err_cnt <= 8'd0;
    else if (w_err_inc && r_err_cnt != 8'hFF)
      r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_cnt = r_err_cnt;
`else
  logic w_unused;
  assign w_unused = w_err_inc;
`endif

endmodule
